nibble_scatter4: RTL

Write-side counterpart of the four-lane nibble selector. Each beat carries four 4-bit nibbles, each with a destination word (A or B) and a nibble slot (0–7). The block deposits them into two 32-bit accumulators. When an accumulator has all eight slots filled, the completed word is emitted over a valid/ready output port. It sits where the selector's nibble lanes return to the word domain, rebuilding 32-bit words from scattered nibbles.

---
 rtl/nibble_scatter4_if.sv | 25 ++
 rtl/nibble_scatter4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nibble_scatter4_if.sv
// Beat-in / word-out handshake bundle for nibble_scatter4.
// The slave modport is the scatter block; the master modport is its environment.
interface nibble_scatter4_if;
    logic [15:0] NIBBLE_IN;
    logic [11:0] sc_dst_A;
    logic [11:0] sc_dst_B;
    logic [3:0]  sc_SEL;
    logic [3:0]  sc_EN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] DATA_OUT;
    logic        OUT_ID;
    logic        OUT_VALID;
    logic        OUT_READY;

    modport slave (
        input  NIBBLE_IN, sc_dst_A, sc_dst_B, sc_SEL, sc_EN, IN_VALID, OUT_READY,
        output IN_READY, DATA_OUT, OUT_ID, OUT_VALID
    );

    modport master (
        output NIBBLE_IN, sc_dst_A, sc_dst_B, sc_SEL, sc_EN, IN_VALID, OUT_READY,
        input  IN_READY, DATA_OUT, OUT_ID, OUT_VALID
    );
endinterface

// File: rtl/nibble_scatter4.sv
// Scatters four nibble lanes per beat into two 32-bit accumulators and emits each completed word.
// Define NIBBLE_SCATTER_ERR_EN to add the sticky ERR_OVR overwrite/collision flag.
module nibble_scatter4 (
    input  logic CLK,
    input  logic RESET,
`ifdef NIBBLE_SCATTER_ERR_EN
    output logic ERR_OVR,
`endif
    nibble_scatter4_if.slave bus
);

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        EMIT_A  = 2'd1,
        EMIT_B  = 2'd2,
        EMIT_AB = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [7:0]  mask_a_q, mask_a_d, mask_b_q, mask_b_d;
    logic [31:0] data_out_q, data_out_d;
    logic        out_id_q, out_id_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;
    logic [2:0]  slot;
`ifdef NIBBLE_SCATTER_ERR_EN
    logic        err_ovr_q, err_ovr_d;
    logic        hit;
    logic [7:0]  wr_a, wr_b;
`endif

    // in_ready_q is only ever high in ACCUM, so it doubles as the state decode for accepts.
    assign accept = bus.IN_VALID & in_ready_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        mask_a_d    = mask_a_q;
        mask_b_d    = mask_b_q;
        data_out_d  = data_out_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        slot        = '0;
`ifdef NIBBLE_SCATTER_ERR_EN
        hit         = 1'b0;
        wr_a        = '0;
        wr_b        = '0;
`endif

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    // Ascending lane order makes the highest enabled lane win a same-beat collision.
                    for (int k = 0; k < 4; k++) begin
                        slot = bus.sc_SEL[k] ? bus.sc_dst_B[3*k +: 3] : bus.sc_dst_A[3*k +: 3];
                        if (bus.sc_EN[k]) begin
                            if (bus.sc_SEL[k]) begin
`ifdef NIBBLE_SCATTER_ERR_EN
                                hit = hit | mask_b_q[slot] | wr_b[slot];
                                wr_b[slot] = 1'b1;
`endif
                                acc_b_d[{slot, 2'b00} +: 4] = bus.NIBBLE_IN[4*k +: 4];
                                mask_b_d[slot] = 1'b1;
                            end else begin
`ifdef NIBBLE_SCATTER_ERR_EN
                                hit = hit | mask_a_q[slot] | wr_a[slot];
                                wr_a[slot] = 1'b1;
`endif
                                acc_a_d[{slot, 2'b00} +: 4] = bus.NIBBLE_IN[4*k +: 4];
                                mask_a_d[slot] = 1'b1;
                            end
                        end
                    end

                    if (&mask_a_d) begin
                        state_d     = (&mask_b_d) ? EMIT_AB : EMIT_A;
                        out_valid_d = 1'b1;
                        data_out_d  = acc_a_d;
                        out_id_d    = 1'b0;
                        in_ready_d  = 1'b0;
                    end else if (&mask_b_d) begin
                        state_d     = EMIT_B;
                        out_valid_d = 1'b1;
                        data_out_d  = acc_b_d;
                        out_id_d    = 1'b1;
                        in_ready_d  = 1'b0;
                    end
                end
            end

            EMIT_A, EMIT_AB: begin
                if (bus.OUT_READY) begin
                    acc_a_d  = '0;
                    mask_a_d = '0;
                    if (state_q == EMIT_AB) begin
                        state_d    = EMIT_B;
                        data_out_d = acc_b_q;
                        out_id_d   = 1'b1;
                    end else begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                        data_out_d  = '0;
                        out_id_d    = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
            end

            EMIT_B: begin
                if (bus.OUT_READY) begin
                    acc_b_d     = '0;
                    mask_b_d    = '0;
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    data_out_d  = '0;
                    out_id_d    = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ACCUM;
            // NOTE: the accumulators are datapath storage but are reset too, since a partial word must not survive reset.
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            mask_a_q    <= '0;
            mask_b_q    <= '0;
            data_out_q  <= '0;
            out_id_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            mask_a_q    <= mask_a_d;
            mask_b_q    <= mask_b_d;
            data_out_q  <= data_out_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef NIBBLE_SCATTER_ERR_EN
    assign err_ovr_d = err_ovr_q | (accept & hit);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) err_ovr_q <= 1'b0;
        else       err_ovr_q <= err_ovr_d;
    end

    assign ERR_OVR = err_ovr_q;
`endif

    // Gated by RESET so no beat is offered while the block is held in reset.
    assign bus.IN_READY  = in_ready_q & ~RESET;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.DATA_OUT  = data_out_q;
    assign bus.OUT_ID    = out_id_q;

endmodule
